// File: rtl/freelist_pkg.sv
// freelist_pkg: shared sizes, index/count types, popcount and lane-compaction helpers for slot_freelist
// Contents: FL_WIDTH/FL_REQS/FL_RETS defaults, IDX_W and CNT_W derived from FL_WIDTH,
// idx_t/cnt_t/lane_cnt_t types, popcount(), lane_rank().
package freelist_pkg;
    localparam int FL_WIDTH = 16;
    localparam int FL_REQS  = 4;
    localparam int FL_RETS  = 4;
    localparam int IDX_W    = $clog2(FL_WIDTH);
    localparam int CNT_W    = $clog2(FL_WIDTH + 1);
    localparam int LANE_W   = $clog2(FL_REQS + 1);
    localparam int LANE_IX  = $clog2(FL_REQS);
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LANE_W-1:0] lane_cnt_t;

    function automatic cnt_t popcount(input logic [FL_WIDTH-1:0] v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < FL_WIDTH; i++) c = c + cnt_t'(v[i]);
        return c;
    endfunction

    // Number of requesting lanes strictly below `lane`; lane_rank(req, FL_REQS) is the total.
    function automatic lane_cnt_t lane_rank(input logic [FL_REQS-1:0] req, input int lane);
        lane_cnt_t r;
        r = '0;
        for (int i = 0; i < FL_REQS; i++) if (i < lane) r = r + lane_cnt_t'(req[i]);
        return r;
    endfunction
endpackage

// File: rtl/freelist_pick.sv
// freelist_pick: combinational picker of the REQS lowest set bits of a candidate mask
// Ports: cand (candidate free mask), pick_oh (k-th lowest set bit, one-hot, 0 if none),
// pick_idx (encoded index of pick_oh, 0 if none).
module freelist_pick
    import freelist_pkg::*;
#(
    parameter int WIDTH = FL_WIDTH,
    parameter int REQS  = FL_REQS
) (
    input  logic [WIDTH-1:0]            cand,
    output logic [REQS-1:0][WIDTH-1:0]  pick_oh,
    output logic [REQS-1:0][IDX_W-1:0]  pick_idx
);
    logic [WIDTH-1:0] rem;

    always_comb begin
        rem      = cand;
        pick_oh  = '0;
        pick_idx = '0;
        for (int k = 0; k < REQS; k++) begin
            pick_oh[k] = rem & (-rem);
            rem        = rem & ~pick_oh[k];
            for (int i = 0; i < WIDTH; i++) if (pick_oh[k][i]) pick_idx[k] = IDX_W'(i);
        end
    end
endmodule

// File: rtl/slot_freelist.sv
// slot_freelist: bitmap free-list with all-or-nothing multi-lane allocation and multi-lane reclaim
// Ports: clock/reset (sync, active-high); alloc_req -> alloc_ok/alloc_idx (combinational);
// release_valid/release_idx (applied at the edge); free_count/empty/full/error (registered state).
// Optional: SLOT_FREELIST_RELEASE_BYPASS_EN makes same-cycle releases grantable.
module slot_freelist
    import freelist_pkg::*;
#(
    parameter int WIDTH = FL_WIDTH,
    parameter int REQS  = FL_REQS,
    parameter int RETS  = FL_RETS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [REQS-1:0]            alloc_req,
    output logic                       alloc_ok,
    output logic [REQS-1:0][IDX_W-1:0] alloc_idx,
    input  logic [RETS-1:0]            release_valid,
    input  logic [RETS-1:0][IDX_W-1:0] release_idx,
    output logic [CNT_W-1:0]           free_count,
    output logic                       empty,
    output logic                       full,
    output logic                       error
);
    logic [WIDTH-1:0]            free_q, rel_mask, cand, grant_mask, free_d;
    logic [REQS-1:0][WIDTH-1:0]  pick_oh;
    logic [REQS-1:0][IDX_W-1:0]  pick_idx;
    logic                        rel_err, commit;
    lane_cnt_t                   rk;

    // A lane hitting an index already free, or already set by a lower lane, is a protocol error.
    always_comb begin
        rel_mask = '0;
        rel_err  = 1'b0;
        for (int j = 0; j < RETS; j++) begin
            if (release_valid[j]) begin
                if (int'(release_idx[j]) >= WIDTH) rel_err = 1'b1;
                else begin
                    if (free_q[release_idx[j]] || rel_mask[release_idx[j]]) rel_err = 1'b1;
                    rel_mask[release_idx[j]] = 1'b1;
                end
            end
        end
    end

`ifdef SLOT_FREELIST_RELEASE_BYPASS_EN
    assign cand = free_q | rel_mask;
`else
    assign cand = free_q;
`endif

    freelist_pick #(.WIDTH(WIDTH), .REQS(REQS)) u_pick (
        .cand     (cand),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

    assign alloc_ok = popcount(cand) >= cnt_t'(lane_rank(alloc_req, REQS));
    assign commit   = alloc_ok && |alloc_req;

    // Each requesting lane takes the pick matching its rank among requesting lanes.
    always_comb begin
        alloc_idx  = '0;
        grant_mask = '0;
        rk         = '0;
        for (int l = 0; l < REQS; l++) begin
            rk = lane_rank(alloc_req, l);
            if (alloc_req[l]) begin
                alloc_idx[l] = pick_idx[rk[LANE_IX-1:0]];
                grant_mask   = grant_mask | pick_oh[rk[LANE_IX-1:0]];
            end
        end
    end

    // Grant clears after release sets, so an alloc/release collision ends allocated.
    assign free_d = (free_q | rel_mask) & ~(commit ? grant_mask : '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            free_q     <= '1;
            free_count <= CNT_W'(WIDTH);
            error      <= 1'b0;
        end else begin
            free_q     <= free_d;
            free_count <= popcount(free_d);
            error      <= error | rel_err;
        end
    end

    assign empty = free_count == '0;
    assign full  = free_count == CNT_W'(WIDTH);
endmodule

// File: tb/tb_slot_freelist.sv
// tb_slot_freelist: directed and random checks of slot_freelist against a list-based reference model
module tb_slot_freelist;
    import freelist_pkg::*;

`ifdef SLOT_FREELIST_RELEASE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      alloc_req = '0;
    logic            alloc_ok;
    logic [3:0][3:0] alloc_idx;
    logic [3:0]      release_valid = '0;
    logic [3:0][3:0] release_idx = '0;
    logic [4:0]      free_count;
    logic            empty, full, error;

    always #5 clock = ~clock;

    slot_freelist dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_ok      (alloc_ok),
        .alloc_idx     (alloc_idx),
        .release_valid (release_valid),
        .release_idx   (release_idx),
        .free_count    (free_count),
        .empty         (empty),
        .full          (full),
        .error         (error)
    );

    int ncmp = 0;
    int nfail = 0;
    bit m_free[16];
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m_free[i]);
        return c;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cyc(input logic [3:0] req, input logic [3:0] rv, input logic [3:0][3:0] ri, input bit rst);
        int  cands[$];
        bit  seen[16];
        bit  errnew;
        bit  ok;
        int  nreq;
        int  k;
        int  e;
        @(negedge clock);
        reset = rst;
        alloc_req = req;
        release_valid = rv;
        release_idx = ri;
        #1;
        chk("free_count", free_count, mcount());
        chk("empty", empty, mcount() == 0);
        chk("full", full, mcount() == 16);
        chk("error", error, m_err);
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        errnew = 1'b0;
        for (int j = 0; j < 4; j++) if (rv[j]) begin
            if (m_free[ri[j]] || seen[ri[j]]) errnew = 1'b1;
            seen[ri[j]] = 1'b1;
        end
        for (int i = 0; i < 16; i++) if (m_free[i] || (BYP && seen[i])) cands.push_back(i);
        nreq = $countones(req);
        ok = cands.size() >= nreq;
        chk("alloc_ok", alloc_ok, ok);
        k = 0;
        for (int l = 0; l < 4; l++) begin
            e = 0;
            if (req[l]) begin
                e = (k < cands.size()) ? cands[k] : 0;
                k++;
            end
            chk($sformatf("alloc_idx%0d", l), alloc_idx[l], e);
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) m_free[i] = 1'b1;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) m_free[i] = m_free[i] | seen[i];
            if (ok) for (int q = 0; q < nreq; q++) m_free[cands[q]] = 1'b0;
            m_err = m_err | errnew;
        end
    endtask

    task automatic post();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0]      r_req, r_rv;
        logic [3:0][3:0] r_ri;
        int              alloc_list[$];
        for (int i = 0; i < 16; i++) m_free[i] = 1'b1;
        m_err = 1'b0;
        cyc(4'b0, 4'b0, '0, 1'b1);
        cyc(4'b0, 4'b0, '0, 1'b1);
        post();
        chk("rst_fc16", free_count, 16);
        chk("rst_full", full, 1);
        chk("rst_empty", empty, 0);
        chk("rst_error", error, 0);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        post();
        chk("plan_fc12", free_count, 12);
        chk("plan_full0", full, 0);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        cyc(4'b0011, 4'b0, '0, 1'b0);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        post();
        chk("plan_short_fc2", free_count, 2);
        cyc(4'b0011, 4'b0, '0, 1'b0);
        cyc(4'b0, 4'b0011, {4'd0, 4'd0, 4'd9, 4'd5}, 1'b0);
        post();
        chk("plan_rel_fc2", free_count, 2);
        cyc(4'b0011, 4'b0, '0, 1'b0);
        post();
        chk("plan_empty", empty, 1);
        cyc(4'b0, 4'b0011, {4'd0, 4'd0, 4'd6, 4'd2}, 1'b0);
        cyc(4'b1010, 4'b0, '0, 1'b0);
        post();
        chk("plan_sparse_empty", empty, 1);
        cyc(4'b0001, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd7}, 1'b0);
        post();
        chk("plan_collide_fc", free_count, BYP ? 0 : 1);
        chk("plan_collide_err", error, 0);
        cyc(4'b0, 4'b0, '0, 1'b1);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        cyc(4'b1111, 4'b0, '0, 1'b0);
        cyc(4'b0, 4'b0011, {4'd0, 4'd0, 4'd8, 4'd8}, 1'b0);
        post();
        chk("plan_dup_err", error, 1);
        chk("plan_dup_fc5", free_count, 5);
        cyc(4'b0, 4'b0, '0, 1'b0);
        cyc(4'b0, 4'b0, '0, 1'b0);
        post();
        chk("plan_err_sticky", error, 1);
        cyc(4'b0, 4'b0, '0, 1'b1);
        cyc(4'b0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, 1'b0);
        post();
        chk("plan_refree_err", error, 1);
        chk("plan_refree_fc16", free_count, 16);
        cyc(4'b0, 4'b0, '0, 1'b1);
        for (int n = 0; n < 500; n++) begin
            alloc_list.delete();
            for (int i = 0; i < 16; i++) if (!m_free[i]) alloc_list.push_back(i);
            r_req = 4'($urandom);
            r_rv = 4'($urandom);
            for (int j = 0; j < 4; j++)
                r_ri[j] = (alloc_list.size() > 0 && $urandom_range(0, 9) < 8)
                    ? 4'(alloc_list[$urandom_range(0, alloc_list.size() - 1)]) : 4'($urandom);
            cyc(r_req, r_rv, r_ri, $urandom_range(0, 59) == 0);
        end
        cyc(4'b0, 4'b0, '0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
